sram_mc_arb: RTL and testbench

- Parametrised multi-channel successor to the single-port octree node SRAM.
- NUM_CH requestors share one single-port memory array through round-robin arbitration with valid/ready request handshakes.
- Writes support byte masks; read latency is configurable and fully pipelined; out-of-range accesses are flagged.
- Sits between the octree traversal/update engines and node storage.

---
 rtl/sram_mc_arb_pkg.sv | 26 ++
 rtl/sram_mc_arb_if.sv | 29 ++
 rtl/sram_mc_arb_rr_arbiter.sv | 48 ++++
 rtl/sram_mc_arb.sv | 165 ++++++++++++++++
 tb/tb_sram_mc_arb.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/sram_mc_arb_pkg.sv
// sram_mc_pkg: shared helpers and types for the multi-channel SRAM arbiter.
//   clamp_clog2 : $clog2 clamped to a minimum of 1 (pointer/index widths).
//   bytes_of    : number of byte lanes in a data word.
//   rd_pipe_t   : read-pipeline stage (valid, channel tag, out-of-range flag).
// The tag field is sized for the largest legal NUM_CH (8) so the type can live
// in a non-parameterised package; the top derives its own CH_W/BYTES from the
// helpers above.
package sram_mc_pkg;

  localparam int CH_W_MAX = 3;

  function automatic int clamp_clog2(input int n);
    return (n <= 2) ? 32'sd1 : $clog2(n);
  endfunction

  function automatic int bytes_of(input int dw);
    return dw / 8;
  endfunction

  typedef struct packed {
    logic                vld;
    logic [CH_W_MAX-1:0] ch;
    logic                err;
  } rd_pipe_t;

endpackage

// File: rtl/sram_mc_arb_if.sv
// sram_mc_arb_if: request/response bundle between NUM_CH requestors and the
// shared SRAM. Channel i occupies slice i of every packed vector.
//   master modport: requestor side (drives req_*, sees ready and responses)
//   slave  modport: memory side
interface sram_mc_arb_if #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 64
);
  logic [NUM_CH-1:0]              req_valid;
  logic [NUM_CH-1:0]              req_ready;
  logic [NUM_CH-1:0]              req_we;
  logic [NUM_CH*ADDR_WIDTH-1:0]   req_addr;
  logic [NUM_CH*DATA_WIDTH-1:0]   req_wdata;
  logic [NUM_CH*DATA_WIDTH/8-1:0] req_wmask;
  logic [NUM_CH-1:0]              rsp_valid;
  logic [NUM_CH*DATA_WIDTH-1:0]   rsp_data;
  logic [NUM_CH-1:0]              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/sram_mc_arb_rr_arbiter.sv
// rr_arbiter: round-robin grant over N requestors.
//   clk, rst_n   : clock, async active-low reset (pointer returns to 0)
//   i_req[N]     : request vector
//   i_accept     : a granted request transferred this cycle
//   o_grant[N]   : one-hot grant, combinational from i_req and the pointer
//   o_grant_idx  : index of the granted channel (0 when nothing is granted)
module rr_arbiter
  import sram_mc_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N-1:0]                 i_req,
  input  logic                         i_accept,
  output logic [N-1:0]                 o_grant,
  output logic [clamp_clog2(N)-1:0]    o_grant_idx
);
  localparam int W = clamp_clog2(N);

  logic [W-1:0] r_ptr;
  logic         w_found;

  // First requester at or above the pointer, wrapping modulo N.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && i_req[(int'(r_ptr) + k) % N]) begin
        o_grant[(int'(r_ptr) + k) % N] = 1'b1;
        o_grant_idx = W'((int'(r_ptr) + k) % N);
        w_found     = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

  // Pointer moves just past the winner on every transfer, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_accept) begin
      r_ptr <= W'((int'(o_grant_idx) + 1) % N);
    end
  end
endmodule

// File: rtl/sram_mc_arb.sv
// sram_mc_arb: NUM_CH requestors sharing one single-port SRAM through a
// round-robin arbiter. Byte-masked writes, fully pipelined reads with
// RD_LATENCY cycles of latency, out-of-range accesses flagged via rsp_err.
//   clk, rst_n : clock, async active-low reset (memory contents not reset)
//   io_bus     : sram_mc_arb_if slave (req_* in, req_ready/rsp_* out)
// Optional build macro SRAM_MC_PERF_CNT_EN adds per-channel 32-bit
// read/write counters (perf_rd_cnt, perf_wr_cnt) and a sync clear perf_clr.
module sram_mc_arb
  import sram_mc_pkg::*;
#(
  parameter int    NUM_CH     = 2,
  parameter int    ADDR_WIDTH = 15,
  parameter int    DATA_WIDTH = 64,
  parameter int    MEM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int    RD_LATENCY = 1,
  parameter string INIT_FILE  = "sram.txt"
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sram_mc_arb_if.slave           io_bus
`ifdef SRAM_MC_PERF_CNT_EN
  ,
  input  logic                   perf_clr,
  output logic [NUM_CH*32-1:0]   perf_rd_cnt,
  output logic [NUM_CH*32-1:0]   perf_wr_cnt
`endif
);
  localparam int BYTES = bytes_of(DATA_WIDTH);
  localparam int CH_W  = clamp_clog2(NUM_CH);
  localparam int IDX_W = clamp_clog2(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic [NUM_CH-1:0]     w_req_vld;
  logic [NUM_CH-1:0]     w_grant;
  logic [CH_W-1:0]       w_gidx;
  logic                  w_xfer;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [BYTES-1:0]      w_wmask;
  logic                  w_in_range;
  logic [IDX_W-1:0]      w_idx;
  rd_pipe_t              w_rd_in;
  logic [DATA_WIDTH-1:0] w_rd_data;
  rd_pipe_t              w_last;
  logic [DATA_WIDTH-1:0] w_last_data;

  logic [NUM_CH-1:0]            r_rsp_valid;
  logic [NUM_CH-1:0]            r_rsp_err;
  logic [NUM_CH*DATA_WIDTH-1:0] r_rsp_data;

  // Nothing is granted while reset is asserted, so no write can sneak in.
  assign w_req_vld = io_bus.req_valid & {NUM_CH{rst_n}};

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (w_req_vld),
    .i_accept    (w_xfer),
    .o_grant     (w_grant),
    .o_grant_idx (w_gidx)
  );

  assign w_xfer           = |(w_req_vld & w_grant);
  assign io_bus.req_ready = w_grant;

  // Select the winner's payload and classify the access.
  always_comb begin
    w_we       = io_bus.req_we[w_gidx];
    w_addr     = io_bus.req_addr[int'(w_gidx)*ADDR_WIDTH +: ADDR_WIDTH];
    w_wdata    = io_bus.req_wdata[int'(w_gidx)*DATA_WIDTH +: DATA_WIDTH];
    w_wmask    = io_bus.req_wmask[int'(w_gidx)*BYTES +: BYTES];
    w_in_range = ({1'b0, w_addr} < (ADDR_WIDTH+1)'(MEM_DEPTH));
    w_idx      = w_addr[IDX_W-1:0];
    w_rd_in.vld = w_xfer & ~w_we;
    w_rd_in.ch  = CH_W_MAX'(w_gidx);
    w_rd_in.err = ~w_in_range;
    w_rd_data   = w_in_range ? r_mem[w_idx] : '0;
  end

  // Byte-masked write; out-of-range writes are silently dropped.
  always_ff @(posedge clk) begin
    if (w_xfer && w_we && w_in_range) begin
      for (int b = 0; b < BYTES; b++) begin
        if (w_wmask[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
      end
    end
  end

  // The output register is the last latency stage, so RD_LATENCY-1 stages
  // sit between the array sample and the response.
  if (RD_LATENCY == 1) begin : g_lat1
    assign w_last      = w_rd_in;
    assign w_last_data = w_rd_data;
  end else begin : g_latn
    rd_pipe_t              r_pipe  [RD_LATENCY-1];
    logic [DATA_WIDTH-1:0] r_pdata [RD_LATENCY-1];

    // Valid/tag stages: cleared by reset so in-flight reads are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < RD_LATENCY-1; k++) r_pipe[k] <= '0;
      end else begin
        r_pipe[0] <= w_rd_in;
        for (int k = 1; k < RD_LATENCY-1; k++) r_pipe[k] <= r_pipe[k-1];
      end
    end

    // Data stages: qualified by the valid bits, no reset needed.
    always_ff @(posedge clk) begin
      r_pdata[0] <= w_rd_data;
      for (int k = 1; k < RD_LATENCY-1; k++) r_pdata[k] <= r_pdata[k-1];
    end

    assign w_last      = r_pipe[RD_LATENCY-2];
    assign w_last_data = r_pdata[RD_LATENCY-2];
  end

  // Demultiplex the final stage to its channel; data holds between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= '0;
      r_rsp_err   <= '0;
      r_rsp_data  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_last.vld && (w_last.ch == CH_W_MAX'(c))) begin
          r_rsp_valid[c] <= 1'b1;
          r_rsp_err[c]   <= w_last.err;
          r_rsp_data[c*DATA_WIDTH +: DATA_WIDTH] <= w_last_data;
        end else begin
          r_rsp_valid[c] <= 1'b0;
          r_rsp_err[c]   <= 1'b0;
        end
      end
    end
  end

  assign io_bus.rsp_valid = r_rsp_valid;
  assign io_bus.rsp_err   = r_rsp_err;
  assign io_bus.rsp_data  = r_rsp_data;

`ifdef SRAM_MC_PERF_CNT_EN
  logic [NUM_CH*32-1:0] r_perf_rd;
  logic [NUM_CH*32-1:0] r_perf_wr;

  // Per-channel access counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_rd <= '0;
      r_perf_wr <= '0;
    end else if (perf_clr) begin
      r_perf_rd <= '0;
      r_perf_wr <= '0;
    end else if (w_xfer) begin
      if (w_we) r_perf_wr[int'(w_gidx)*32 +: 32] <= r_perf_wr[int'(w_gidx)*32 +: 32] + 32'd1;
      else      r_perf_rd[int'(w_gidx)*32 +: 32] <= r_perf_rd[int'(w_gidx)*32 +: 32] + 32'd1;
    end
  end

  assign perf_rd_cnt = r_perf_rd;
  assign perf_wr_cnt = r_perf_wr;
`endif
endmodule

// File: tb/tb_sram_mc_arb.sv
// Directed bench: three instances (RD_LATENCY 1, 3, 2) with NUM_CH=2 and
// MEM_DEPTH=1024, sharing clock and reset.
module tb_sram_mc_arb;
  logic clk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  sram_mc_arb_if #(.NUM_CH(2), .ADDR_WIDTH(15), .DATA_WIDTH(64)) ifa ();
  sram_mc_arb_if #(.NUM_CH(2), .ADDR_WIDTH(15), .DATA_WIDTH(64)) ifb ();
  sram_mc_arb_if #(.NUM_CH(2), .ADDR_WIDTH(15), .DATA_WIDTH(64)) ifc ();

  sram_mc_arb #(.NUM_CH(2), .ADDR_WIDTH(15), .DATA_WIDTH(64), .MEM_DEPTH(1024),
                .RD_LATENCY(1), .INIT_FILE("")) dut_a (.clk(clk), .rst_n(rst_n), .io_bus(ifa));
  sram_mc_arb #(.NUM_CH(2), .ADDR_WIDTH(15), .DATA_WIDTH(64), .MEM_DEPTH(1024),
                .RD_LATENCY(3), .INIT_FILE("")) dut_b (.clk(clk), .rst_n(rst_n), .io_bus(ifb));
  sram_mc_arb #(.NUM_CH(2), .ADDR_WIDTH(15), .DATA_WIDTH(64), .MEM_DEPTH(1024),
                .RD_LATENCY(2), .INIT_FILE("")) dut_c (.clk(clk), .rst_n(rst_n), .io_bus(ifc));

  localparam logic [63:0] D0 = 64'h0A0A_0000_0000_0020;
  localparam logic [63:0] D1 = 64'h0B0B_0000_0000_0021;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input int ch, input logic we, input logic [14:0] addr,
                       input logic [63:0] data, input logic [7:0] mask);
    ifa.req_we[ch]             = we;
    ifa.req_addr[ch*15 +: 15]  = addr;
    ifa.req_wdata[ch*64 +: 64] = data;
    ifa.req_wmask[ch*8 +: 8]   = mask;
    ifa.req_valid[ch]          = 1'b1;
  endtask

  task automatic drv_b(input logic we, input logic [14:0] addr, input logic [63:0] data);
    ifb.req_we[0]       = we;
    ifb.req_addr[14:0]  = addr;
    ifb.req_wdata[63:0] = data;
    ifb.req_wmask[7:0]  = 8'hFF;
    ifb.req_valid[0]    = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    ifa.req_valid = '0; ifa.req_we = '0; ifa.req_addr = '0; ifa.req_wdata = '0; ifa.req_wmask = '0;
    ifb.req_valid = '0; ifb.req_we = '0; ifb.req_addr = '0; ifb.req_wdata = '0; ifb.req_wmask = '0;
    ifc.req_valid = '0; ifc.req_we = '0; ifc.req_addr = '0; ifc.req_wdata = '0; ifc.req_wmask = '0;

    // Reset state, with requests present that must not be granted.
    ifa.req_valid = 2'b11;
    repeat (3) step();
    chk("rst_ready",     64'(ifa.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(ifa.rsp_valid), 64'd0);
    chk("rst_rsp_err",   64'(ifa.rsp_err),   64'd0);
    chk("rst_rsp_data0", ifa.rsp_data[63:0],   64'd0);
    chk("rst_rsp_data1", ifa.rsp_data[127:64], 64'd0);
    ifa.req_valid = '0;
    rst_n = 1'b1;
    step();

    // Full write then read, latency 1.
    drv_a(0, 1'b1, 15'h010, 64'h1122334455667788, 8'hFF);
    #1 chk("a_wr_ready", 64'(ifa.req_ready), 64'd1);
    step();
    drv_a(0, 1'b0, 15'h010, 64'd0, 8'h00);
    step();
    chk("a_rd_valid", 64'(ifa.rsp_valid), 64'd1);
    chk("a_rd_data",  ifa.rsp_data[63:0], 64'h1122334455667788);
    chk("a_rd_err",   64'(ifa.rsp_err),   64'd0);
    ifa.req_valid = '0;
    step();
    chk("a_pulse_end", 64'(ifa.rsp_valid), 64'd0);
    chk("a_data_hold", ifa.rsp_data[63:0], 64'h1122334455667788);

    // Byte mask: only the low four bytes change.
    drv_a(0, 1'b1, 15'h010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    step();
    drv_a(0, 1'b0, 15'h010, 64'd0, 8'h00);
    step();
    chk("a_mask_data", ifa.rsp_data[63:0], 64'h11223344FFFFFFFF);

    // Zero mask is a no-op write.
    drv_a(0, 1'b1, 15'h010, 64'd0, 8'h00);
    step();
    drv_a(0, 1'b0, 15'h010, 64'd0, 8'h00);
    step();
    chk("a_mask0_data", ifa.rsp_data[63:0], 64'h11223344FFFFFFFF);
    ifa.req_valid = '0;

    // Contention: preload, leaving the pointer at 0, then both read for 4 cycles.
    drv_a(0, 1'b1, 15'h020, D0, 8'hFF);
    step();
    ifa.req_valid = '0;
    drv_a(1, 1'b1, 15'h021, D1, 8'hFF);
    step();
    drv_a(0, 1'b0, 15'h020, 64'd0, 8'h00);
    drv_a(1, 1'b0, 15'h021, 64'd0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      #1 chk("cont_ready", 64'(ifa.req_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
      step();
      chk("cont_rsp_valid", 64'(ifa.rsp_valid), (i % 2 == 0) ? 64'd1 : 64'd2);
      chk("cont_rsp_data", (i % 2 == 0) ? ifa.rsp_data[63:0] : ifa.rsp_data[127:64],
          (i % 2 == 0) ? D0 : D1);
    end
    ifa.req_valid = '0;
    step();

    // Out of range: 2000 aliases 976 but must neither write nor read it.
    drv_a(0, 1'b1, 15'd976, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF);
    step();
    drv_a(0, 1'b1, 15'd2000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
    #1 chk("oor_wr_ready", 64'(ifa.req_ready), 64'd1);
    step();
    drv_a(0, 1'b0, 15'd2000, 64'd0, 8'h00);
    step();
    chk("oor_rd_valid", 64'(ifa.rsp_valid), 64'd1);
    chk("oor_rd_err",   64'(ifa.rsp_err),   64'd1);
    chk("oor_rd_data",  ifa.rsp_data[63:0], 64'd0);
    drv_a(0, 1'b0, 15'd976, 64'd0, 8'h00);
    step();
    chk("alias_data", ifa.rsp_data[63:0], 64'hA5A5_A5A5_A5A5_A5A5);
    chk("alias_err",  64'(ifa.rsp_err),   64'd0);
    ifa.req_valid = '0;

    // Latency 3: back-to-back reads of 0,1,2.
    drv_b(1'b1, 15'd0, 64'h100); step();
    drv_b(1'b1, 15'd1, 64'h101); step();
    drv_b(1'b1, 15'd2, 64'h102); step();
    drv_b(1'b0, 15'd0, 64'd0); step();
    chk("b_lat_e0", 64'(ifb.rsp_valid), 64'd0);
    drv_b(1'b0, 15'd1, 64'd0); step();
    chk("b_lat_e1", 64'(ifb.rsp_valid), 64'd0);
    drv_b(1'b0, 15'd2, 64'd0); step();
    chk("b_rsp0_valid", 64'(ifb.rsp_valid), 64'd1);
    chk("b_rsp0_data",  ifb.rsp_data[63:0], 64'h100);
    ifb.req_valid = '0;
    step();
    chk("b_rsp1_valid", 64'(ifb.rsp_valid), 64'd1);
    chk("b_rsp1_data",  ifb.rsp_data[63:0], 64'h101);
    step();
    chk("b_rsp2_valid", 64'(ifb.rsp_valid), 64'd1);
    chk("b_rsp2_data",  ifb.rsp_data[63:0], 64'h102);
    step();
    chk("b_idle", 64'(ifb.rsp_valid), 64'd0);

    // Write followed next cycle by read of the same address.
    drv_b(1'b1, 15'd5, 64'h55); step();
    drv_b(1'b0, 15'd5, 64'd0); step();
    ifb.req_valid = '0;
    chk("b_raw_e0", 64'(ifb.rsp_valid), 64'd0);
    step();
    chk("b_raw_e1", 64'(ifb.rsp_valid), 64'd0);
    step();
    chk("b_raw_valid", 64'(ifb.rsp_valid), 64'd1);
    chk("b_raw_data",  ifb.rsp_data[63:0], 64'h55);

    // Reset right after a latency-2 read is accepted: no response ever.
    ifc.req_addr[14:0] = 15'd3;
    ifc.req_valid      = 2'b01;
    #1 chk("c_rd_ready", 64'(ifc.req_ready), 64'd1);
    step();
    rst_n = 1'b0;
    ifc.req_valid = '0;
    #1 chk("c_rst_valid", 64'(ifc.rsp_valid), 64'd0);
    step();
    chk("c_rst_valid2", 64'(ifc.rsp_valid), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("c_no_rsp", 64'(ifc.rsp_valid), 64'd0);
    end

    // Pointer back at 0: channel 0 wins, then channel 1.
    ifc.req_addr  = {15'd2000, 15'd2000};
    ifc.req_valid = 2'b11;
    #1 chk("c_ptr0_ready", 64'(ifc.req_ready), 64'd1);
    step();
    chk("c_ptr1_ready", 64'(ifc.req_ready), 64'd2);
    ifc.req_valid = '0;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
